// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers 640x480@60 VGA timing from active-low hsync/vsync.
// Measures line/frame lengths, declares lock after LOCK_FRAMES consecutive good
// frames, and regenerates display-enable with pixel coordinates.
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   vga_hs, vga_vs  active-low syncs, synchronous to clk
//   h_pos, v_pos    recovered horizontal/vertical counts
//   de, x, y        active-video enable and pixel coordinates (combinational)
//   locked          timing lock indicator
//   h_err, v_err    one-cycle pulses for bad line / bad frame or stray vsync
//   h_len, v_len    last measured line length (clocks) / frame length (lines)
module vga_sync_rx #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_DISP      = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_DISP      = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vga_hs,
    input  logic       vga_vs,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos,
    output logic       de,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic [9:0] h_len,
    output logic [9:0] v_len
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned Y_W   = 9;

    localparam logic [POS_W-1:0] POS_MAX  = '1;
    localparam logic [POS_W-1:0] H_TOT    = POS_W'(H_TOTAL);
    localparam logic [POS_W-1:0] V_TOT    = POS_W'(V_TOTAL);
    localparam logic [POS_W-1:0] H_ACT_LO = POS_W'(H_SYNC + H_BACK);
    localparam logic [POS_W-1:0] H_ACT_HI = POS_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [POS_W-1:0] V_ACT_LO = POS_W'(V_SYNC + V_BACK);
    localparam logic [POS_W-1:0] V_ACT_HI = POS_W'(V_SYNC + V_BACK + V_DISP);
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             hs_p1_q, hs_p1_d, hs_p2_q, hs_p2_d;
    logic             vs_p1_q, vs_p1_d, vs_p2_q, vs_p2_d;
    logic [POS_W-1:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
    logic [POS_W-1:0] h_len_q, h_len_d, v_len_q, v_len_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic             frame_bad_q, frame_bad_d;
    logic             locked_q, locked_d;
    logic             h_err_q, h_err_d, v_err_q, v_err_d;

    logic             hs_fall, vs_fall;
    logic [POS_W-1:0] h_inc, v_inc;
    logic [CNT_W-1:0] good_inc;
    logic             h_bad, v_bad;
    logic             h_act, v_act;

    // Falling-edge detect on the delayed sync samples.
    assign hs_fall  = hs_p2_q & ~hs_p1_q;
    assign vs_fall  = vs_p2_q & ~vs_p1_q;
    assign h_inc    = h_pos_q + POS_W'(1);
    assign v_inc    = v_pos_q + POS_W'(1);
    assign good_inc = (good_cnt_q == CNT_MAX) ? good_cnt_q : good_cnt_q + CNT_W'(1);
    assign h_bad    = hs_fall && (h_inc != H_TOT);
    assign v_bad    = (v_inc != V_TOT);

    // Next-state: sync pipeline, position counters, lock FSM and error pulses.
    always_comb begin
        state_d     = state_q;
        hs_p1_d     = vga_hs;
        hs_p2_d     = hs_p1_q;
        vs_p1_d     = vga_vs;
        vs_p2_d     = vs_p1_q;
        h_pos_d     = h_pos_q;
        v_pos_d     = v_pos_q;
        h_len_d     = h_len_q;
        v_len_d     = v_len_q;
        good_cnt_d  = good_cnt_q;
        frame_bad_d = frame_bad_q;
        h_err_d     = 1'b0;
        v_err_d     = 1'b0;

        if (hs_fall) begin
            h_pos_d = '0;
            h_len_d = h_inc;
            if (vs_fall) begin
                v_pos_d = '0;
                v_len_d = v_inc;
            end else if (v_pos_q != POS_MAX) begin
                v_pos_d = v_inc;
            end
        end else if (h_pos_q != POS_MAX) begin
            h_pos_d = h_inc;
        end

        case (state_q)
            SEARCH: begin
                if (vs_fall && hs_fall) begin
                    state_d     = TRACK;
                    good_cnt_d  = '0;
                    frame_bad_d = 1'b0;
                end
            end
            default: begin
                // A saturated counter means the syncs have gone away: drop silently.
                if (h_pos_q == POS_MAX || v_pos_q == POS_MAX) begin
                    state_d = SEARCH;
                end else begin
                    if (h_bad) begin
                        h_err_d     = 1'b1;
                        frame_bad_d = 1'b1;
                        if (state_q == LOCKED) begin
                            state_d    = TRACK;
                            good_cnt_d = '0;
                        end
                    end
                    if (vs_fall && !hs_fall) begin
                        v_err_d = 1'b1;
                        state_d = SEARCH;
                    end else if (vs_fall && hs_fall) begin
                        frame_bad_d = 1'b0;
                        v_err_d     = v_bad;
                        // frame_bad_q misses an h_err raised this cycle, hence h_bad too.
                        if (!v_bad && !frame_bad_q && !h_bad) begin
                            good_cnt_d = good_inc;
                            if (state_q == TRACK && good_inc == LOCK_CNT) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            good_cnt_d = '0;
                            state_d    = TRACK;
                        end
                    end
                end
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            hs_p1_q     <= 1'b1;
            hs_p2_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            vs_p2_q     <= 1'b1;
            h_pos_q     <= '0;
            v_pos_q     <= '0;
            h_len_q     <= '0;
            v_len_q     <= '0;
            good_cnt_q  <= '0;
            frame_bad_q <= 1'b0;
            locked_q    <= 1'b0;
            h_err_q     <= 1'b0;
            v_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_p1_q     <= hs_p1_d;
            hs_p2_q     <= hs_p2_d;
            vs_p1_q     <= vs_p1_d;
            vs_p2_q     <= vs_p2_d;
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            h_len_q     <= h_len_d;
            v_len_q     <= v_len_d;
            good_cnt_q  <= good_cnt_d;
            frame_bad_q <= frame_bad_d;
            locked_q    <= locked_d;
            h_err_q     <= h_err_d;
            v_err_q     <= v_err_d;
        end
    end

    // Display window decode straight from the registered counters.
    assign h_act = (h_pos_q >= H_ACT_LO) && (h_pos_q < H_ACT_HI);
    assign v_act = (v_pos_q >= V_ACT_LO) && (v_pos_q < V_ACT_HI);
    assign de    = locked_q && h_act && v_act;
    assign x     = de ? (h_pos_q - H_ACT_LO) : '0;
    assign y     = de ? Y_W'(v_pos_q - V_ACT_LO) : '0;

    assign h_pos  = h_pos_q;
    assign v_pos  = v_pos_q;
    assign h_len  = h_len_q;
    assign v_len  = v_len_q;
    assign locked = locked_q;
    assign h_err  = h_err_q;
    assign v_err  = v_err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives vga_sync_rx from a small timing generator sharing clk.
// Uses reduced timing (60x20 clocks/lines) so each frame is 1200 cycles.
module tb_vga_sync_rx;

    localparam int unsigned HS = 8;
    localparam int unsigned HB = 4;
    localparam int unsigned HD = 40;
    localparam int unsigned HT = 60;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 3;
    localparam int unsigned VD = 10;
    localparam int unsigned VT = 20;
    localparam int unsigned LK = 2;
    localparam int unsigned FR = HT * VT;
    localparam int unsigned HA = HS + HB;
    localparam int unsigned VA = VS + VB;
    localparam int          WAIT_BUDGET = 2 * FR + 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vga_hs, vga_vs;
    logic [9:0] h_pos, v_pos, x, h_len, v_len;
    logic [8:0] y;
    logic       de, locked, h_err, v_err;

    // Generator state
    logic        tx_rst = 1'b1;
    logic        tx_run = 1'b1;
    int unsigned line_len  = HT;
    int unsigned frame_len = VT;
    int unsigned tx_h, tx_v;

    typedef struct {
        int unsigned h;
        int unsigned v;
    } pos_t;
    pos_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int n_herr = 0;
    int n_verr = 0;

    vga_sync_rx #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT),
        .LOCK_FRAMES(LK)
    ) dut (
        .clk(clk), .rst(rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .h_pos(h_pos), .v_pos(v_pos), .de(de), .x(x), .y(y),
        .locked(locked), .h_err(h_err), .v_err(v_err),
        .h_len(h_len), .v_len(v_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge tx_rst) begin
        if (tx_rst) begin
            tx_h <= 0;
            tx_v <= 0;
        end else if (tx_run) begin
            if (tx_h == line_len - 1) begin
                tx_h <= 0;
                tx_v <= (tx_v == frame_len - 1) ? 0 : tx_v + 1;
            end else begin
                tx_h <= tx_h + 1;
            end
        end
    end

    assign vga_hs = tx_run ? (tx_h >= HS) : 1'b1;
    assign vga_vs = tx_run ? (tx_v >= VS) : 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (h_err === 1'b1) n_herr++;
            if (v_err === 1'b1) n_verr++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_tx(input int unsigned h, input int unsigned v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            @(negedge clk);
            if (tx_h == h && tx_v == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({h_pos, v_pos, h_len, v_len} !== 40'd0) begin
            bad++;
            $display("FAIL reset_counters: got h_pos=%0d v_pos=%0d h_len=%0d v_len=%0d want all 0",
                     h_pos, v_pos, h_len, v_len);
        end
        total++;
        if ({locked, de, h_err, v_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got locked=%b de=%b h_err=%b v_err=%b want 0000",
                     locked, de, h_err, v_err);
        end
        total++;
        if ({x, y} !== 19'd0) begin
            bad++;
            $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", x, y);
        end
    endtask

    task automatic test_nominal_lock();
        int   he, ve;
        pos_t e;
        rst = 1'b0;
        tx_rst = 1'b0;
        he = n_herr;
        ve = n_verr;
        sb_q.delete();
        sb_q.push_back('{tx_h, tx_v});
        for (int t = 1; t <= int'(2 * FR + 2); t++) begin
            @(negedge clk);
            sb_q.push_back('{tx_h, tx_v});
            if (sb_q.size() > 2) begin
                e = sb_q.pop_front();
                total++;
                if (h_pos !== 10'(e.h) || v_pos !== 10'(e.v)) begin
                    bad++;
                    $display("FAIL nominal_pos t=%0d: got h=%0d v=%0d want h=%0d v=%0d",
                             t, h_pos, v_pos, e.h, e.v);
                end
            end
            if (t == int'(2 * FR + 1)) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("FAIL nominal_prelock: got locked=%b want 0", locked);
                end
            end
            if (t == int'(2 * FR + 2)) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL nominal_lock: got locked=%b want 1", locked);
                end
            end
        end
        total++;
        if (n_herr != he || n_verr != ve) begin
            bad++;
            $display("FAIL nominal_errs: got h_err pulses=%0d v_err pulses=%0d want 0 0",
                     n_herr - he, n_verr - ve);
        end
        total++;
        if (h_len !== 10'(HT) || v_len !== 10'(VT)) begin
            bad++;
            $display("FAIL nominal_len: got h_len=%0d v_len=%0d want %0d %0d", h_len, v_len, HT, VT);
        end
    endtask

    task automatic test_coords();
        pos_t        e;
        bit          de_e;
        int unsigned x_e, y_e;
        sb_q.delete();
        sb_q.push_back('{tx_h, tx_v});
        for (int t = 1; t <= int'(FR + 2); t++) begin
            @(negedge clk);
            sb_q.push_back('{tx_h, tx_v});
            if (sb_q.size() > 2) begin
                e    = sb_q.pop_front();
                de_e = (e.h >= HA) && (e.h < HA + HD) && (e.v >= VA) && (e.v < VA + VD);
                x_e  = de_e ? e.h - HA : 0;
                y_e  = de_e ? e.v - VA : 0;
                total++;
                if (locked !== 1'b1 || de !== de_e || x !== 10'(x_e) || y !== 9'(y_e) ||
                    h_pos !== 10'(e.h) || v_pos !== 10'(e.v)) begin
                    bad++;
                    $display("FAIL coords at tx(%0d,%0d): got lk=%b de=%b x=%0d y=%0d want lk=1 de=%b x=%0d y=%0d",
                             e.h, e.v, locked, de, x, y, de_e, x_e, y_e);
                end
                if (e.h == HA && e.v == VA) begin
                    total++;
                    if (de !== 1'b1 || x !== 10'd0 || y !== 9'd0) begin
                        bad++;
                        $display("FAIL coord_first: got de=%b x=%0d y=%0d want 1 0 0", de, x, y);
                    end
                end
                if (e.h == HA + HD - 1 && e.v == VA + VD - 1) begin
                    total++;
                    if (de !== 1'b1 || x !== 10'(HD - 1) || y !== 9'(VD - 1)) begin
                        bad++;
                        $display("FAIL coord_last: got de=%b x=%0d y=%0d want 1 %0d %0d",
                                 de, x, y, HD - 1, VD - 1);
                    end
                end
                if (e.h == HA + HD && e.v == VA) begin
                    total++;
                    if (de !== 1'b0 || x !== 10'd0 || y !== 9'd0) begin
                        bad++;
                        $display("FAIL coord_past_edge: got de=%b x=%0d y=%0d want 0 0 0", de, x, y);
                    end
                end
            end
        end
    endtask

    task automatic test_short_line();
        bit ok;
        int he, ve;
        wait_tx(0, 7, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL short_wait: got timeout want tx line 7");
        end
        line_len = HT - 1;
        @(negedge clk);
        wait_tx(0, 8, ok);
        line_len = HT;
        he = n_herr;
        ve = n_verr;
        @(negedge clk);
        total++;
        if (locked !== 1'b1 || h_err !== 1'b0) begin
            bad++;
            $display("FAIL short_before: got locked=%b h_err=%b want 1 0", locked, h_err);
        end
        @(negedge clk);
        total++;
        if (h_err !== 1'b1 || h_len !== 10'(HT - 1) || locked !== 1'b0) begin
            bad++;
            $display("FAIL short_detect: got h_err=%b h_len=%0d locked=%b want 1 %0d 0",
                     h_err, h_len, locked, HT - 1);
        end
        wait_tx(0, 0, ok);
        repeat (2 * FR + 1) @(negedge clk);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL short_prelock: got locked=%b want 0", locked);
        end
        @(negedge clk);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL short_relock: got locked=%b want 1", locked);
        end
        total++;
        if (n_herr != he + 1 || n_verr != ve || v_len !== 10'(VT)) begin
            bad++;
            $display("FAIL short_counts: got h_err pulses=%0d v_err pulses=%0d v_len=%0d want 1 0 %0d",
                     n_herr - he, n_verr - ve, v_len, VT);
        end
    endtask

    task automatic test_bad_frame();
        bit ok;
        int he, ve;
        wait_tx(0, 1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL badframe_wait: got timeout want tx line 1");
        end
        frame_len = VT - 1;
        wait_tx(0, 0, ok);
        frame_len = VT;
        he = n_herr;
        ve = n_verr;
        @(negedge clk);
        total++;
        if (locked !== 1'b1 || v_err !== 1'b0) begin
            bad++;
            $display("FAIL badframe_before: got locked=%b v_err=%b want 1 0", locked, v_err);
        end
        @(negedge clk);
        total++;
        if (v_err !== 1'b1 || v_len !== 10'(VT - 1) || locked !== 1'b0) begin
            bad++;
            $display("FAIL badframe_detect: got v_err=%b v_len=%0d locked=%b want 1 %0d 0",
                     v_err, v_len, locked, VT - 1);
        end
        repeat (2 * FR - 1) @(negedge clk);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL badframe_prelock: got locked=%b want 0", locked);
        end
        @(negedge clk);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL badframe_relock: got locked=%b want 1", locked);
        end
        total++;
        if (n_herr != he || n_verr != ve + 1) begin
            bad++;
            $display("FAIL badframe_counts: got h_err pulses=%0d v_err pulses=%0d want 0 1",
                     n_herr - he, n_verr - ve);
        end
    endtask

    task automatic test_loss_of_sync();
        int he, ve;
        @(negedge clk);
        tx_run = 1'b0;
        he = n_herr;
        ve = n_verr;
        repeat (1100) @(negedge clk);
        total++;
        if (h_pos !== 10'd1023 || locked !== 1'b0 || de !== 1'b0) begin
            bad++;
            $display("FAIL loss_timeout: got h_pos=%0d locked=%b de=%b want 1023 0 0", h_pos, locked, de);
        end
        total++;
        if (n_herr != he || n_verr != ve) begin
            bad++;
            $display("FAIL loss_errs: got h_err pulses=%0d v_err pulses=%0d want 0 0",
                     n_herr - he, n_verr - ve);
        end
        tx_run = 1'b1;
        tx_rst = 1'b1;
        #1;
        tx_rst = 1'b0;
        repeat (2 * FR + 1) @(negedge clk);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL loss_prelock: got locked=%b want 0", locked);
        end
        @(negedge clk);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL loss_relock: got locked=%b want 1", locked);
        end
        total++;
        if (n_herr != he || n_verr != ve) begin
            bad++;
            $display("FAIL loss_relock_errs: got h_err pulses=%0d v_err pulses=%0d want 0 0",
                     n_herr - he, n_verr - ve);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_tx(HA + 8, VA + 3, ok);
        repeat (2) @(negedge clk);
        total++;
        if (!ok || de !== 1'b1 || x !== 10'd8 || y !== 9'd3) begin
            bad++;
            $display("FAIL areset_before: got ok=%b de=%b x=%0d y=%0d want 1 1 8 3", ok, de, x, y);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (locked !== 1'b0 || de !== 1'b0 || h_pos !== 10'd0 || x !== 10'd0) begin
            bad++;
            $display("FAIL areset_immediate: got locked=%b de=%b h_pos=%0d x=%0d want 0 0 0 0",
                     locked, de, h_pos, x);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_tx(0, 0, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL areset_wait: got timeout want frame start");
        end
        repeat (2 * FR + 1) @(negedge clk);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL areset_prelock: got locked=%b want 0", locked);
        end
        @(negedge clk);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL areset_relock: got locked=%b want 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_coords();
        test_short_line();
        test_bad_frame();
        test_loss_of_sync();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
Receive-side counterpart of the 640x480@60Hz VGA timing generator. Samples active-low vga_hs/vga_vs in the 25 MHz pixel clock domain and recovers horizontal/vertical position. Measures line and frame lengths against nominal timing, declares lock after consecutive good frames, and regenerates display-enable with pixel coordinates. Used for on-board self-check of generator output and as the front end of any VGA capture path.

Parameters:
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch
H_DISP, 640, active pixels per line
H_TOTAL, 800, expected clocks per line
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch
V_DISP, 480, active lines per frame
V_TOTAL, 525, expected lines per frame
LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
clk  in  1  25 MHz pixel clock
rst  in  1  asynchronous reset, active-high
vga_hs  in  1  hsync, active low, synchronous to clk
vga_vs  in  1  vsync, active low, synchronous to clk
h_pos  out  10  recovered horizontal count; 0 = first clock of hsync low
v_pos  out  10  recovered line count; 0 = line where vsync fell
de  out  1  active-video enable (valid only when locked)
x  out  10  pixel column 0..639 when de, else 0
y  out  9  pixel row 0..479 when de, else 0
locked  out  1  timing lock indicator
h_err  out  1  one-cycle pulse: bad line length
v_err  out  1  one-cycle pulse: bad frame length or misaligned vsync edge
h_len  out  10  last measured line length (clocks)
v_len  out  10  last measured frame length (lines)

Behaviour:
- One clock, async active-high reset. On reset: sync pipeline regs = 1, h_pos = v_pos = 0, h_len = v_len = 0, good_cnt = 0, state SEARCH; all outputs 0.
- Input pipeline: hs_d1 <= vga_hs, hs_d2 <= hs_d1 (same for vs). hs_fall = hs_d2 & ~hs_d1; vs_fall likewise.
- Horizontal: on hs_fall, h_pos <= 0, h_len <= h_pos + 1; else h_pos increments and saturates at 1023.
- Vertical, on hs_fall: if vs_fall, v_pos <= 0 and v_len <= v_pos + 1; else v_pos increments, saturating at 1023.
- Latency: with a generator on the same clk, h_pos(t) = tx h_cnt(t-2) and v_pos(t) = tx v_cnt(t-2) once aligned.
- States: SEARCH, TRACK, LOCKED; locked = (state == LOCKED), registered.
- SEARCH: no error pulses. On vs_fall coincident with hs_fall -> TRACK, good_cnt = 0, frame_bad = 0.
- TRACK/LOCKED, hs_fall with h_pos+1 != H_TOTAL:
  - h_err pulses and frame_bad <= 1.
  - LOCKED drops to TRACK with good_cnt = 0.
- TRACK/LOCKED, vs_fall without hs_fall in the same cycle: v_err pulses; -> SEARCH.
- TRACK/LOCKED, vs_fall with hs_fall (frame end):
  - If v_pos+1 != V_TOTAL: v_err pulses.
  - Frame good = no v_err and frame_bad == 0 (frame_bad includes an h_err raised this same cycle).
  - Good frame: good_cnt++. TRACK -> LOCKED when the incremented value == LOCK_FRAMES; good_cnt saturates.
  - Bad frame: good_cnt = 0, state TRACK.
  - In all cases frame_bad <= 0 for the new frame.
- Timeout: h_pos == 1023 or v_pos == 1023 in TRACK/LOCKED -> SEARCH, no error pulse.
- de = locked & (H_SYNC+H_BACK <= h_pos < H_SYNC+H_BACK+H_DISP) & (V_SYNC+V_BACK <= v_pos < V_SYNC+V_BACK+V_DISP).
- x = h_pos - 144 and y = v_pos - 35 when de, else 0. de, x and y are combinational from the registered counters.
- Reset mid-frame: everything returns to reset values immediately; relock needs LOCK_FRAMES full frames after the next vsync edge.

Test Plan:
- Nominal lock: generator and rx share clk, both released from reset at cycle 0 -> state TRACK at cycle 2; locked rises at cycle 840002; h_err/v_err never pulse; h_len = 800, v_len = 525.
- Coordinates: after lock, tx (h_cnt=144, v_cnt=35) -> two cycles later de=1, x=0, y=0. tx (783, 514) -> x=639, y=479. Tx h_cnt=784 -> de=0, x=y=0.
- Short line: while locked, one line of 799 clocks -> one h_err pulse, h_len = 799, locked falls the next cycle. That frame end yields good_cnt = 0, so relock takes 2 further good frames.
- Bad frame: while locked, drive a 524-line frame -> v_err pulse at frame end, v_len = 524, locked = 0; locked returns after 2 good frames.
- Loss of sync: while locked, hold vga_hs = vga_vs = 1 -> h_pos saturates at 1023, state SEARCH, locked = 0, no error pulses. Resume the generator -> relock after 2 frames.
- Async reset mid-frame: assert rst asynchronously while locked -> locked, de and h_pos all 0 immediately, without waiting for a clock edge.
